// File: rtl/cache_mem_pkg.sv
// Shared types and widths for the cache datapaths and the line/burst adapter.
package cache_mem_pkg;

  localparam int LINE_W   = 256;
  localparam int BEAT_W   = 64;
  localparam int NBEATS   = LINE_W / BEAT_W;
  localparam int OFFSET_W = 5;

  typedef enum logic [1:0] {
    IDLE,
    RD_BURST,
    WR_BURST,
    DONE
  } adapter_state_t;

endpackage

// File: rtl/cacheline_adapter.sv
// Converts 256-bit cache line fills/write-backs into 4-beat 64-bit memory bursts.
// Handshake: a beat transfers on every cycle in which mem_read_o or mem_write_o is high
// and mem_resp_i is high; request, address and write beat stay stable until that beat.
module cacheline_adapter
  import cache_mem_pkg::*;
#(
  parameter int s_line   = LINE_W,
  parameter int s_beat   = BEAT_W,
  parameter int s_offset = OFFSET_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              line_read_i,
  input  logic              line_write_i,
  input  logic [31:0]       line_addr_i,
  input  logic [s_line-1:0] line_wdata_i,
  output logic [s_line-1:0] line_rdata_o,
  output logic              line_resp_o,
  output logic              mem_read_o,
  output logic              mem_write_o,
  output logic [31:0]       mem_addr_o,
  output logic [s_beat-1:0] mem_wdata_o,
  input  logic [s_beat-1:0] mem_rdata_i,
  input  logic              mem_resp_i,
  output adapter_state_t    dbg_state
);

  localparam int nbeats = s_line / s_beat;
  localparam int cnt_w  = (nbeats > 1) ? $clog2(nbeats) : 1;
  localparam logic [cnt_w-1:0] last_beat = cnt_w'(nbeats - 1);

  adapter_state_t         state_q, state_d;
  logic [cnt_w-1:0]       cnt_q;
  logic [31-s_offset:0]   addr_q;
  logic [s_line-1:0]      wdata_q;
  logic [s_line-1:0]      rdata_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (line_write_i)     state_d = WR_BURST;
        else if (line_read_i) state_d = RD_BURST;
      end
      RD_BURST: if (mem_resp_i && cnt_q == last_beat) state_d = DONE;
      WR_BURST: if (mem_resp_i && cnt_q == last_beat) state_d = DONE;
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Only the line-aligned part of the address is kept; offset bits are zero on the bus.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (line_write_i) begin
            addr_q  <= line_addr_i[31:s_offset];
            wdata_q <= line_wdata_i;
            cnt_q   <= '0;
          end else if (line_read_i) begin
            addr_q <= line_addr_i[31:s_offset];
            cnt_q  <= '0;
          end
        end
        RD_BURST: begin
          if (mem_resp_i) begin
            rdata_q[int'(cnt_q)*s_beat +: s_beat] <= mem_rdata_i;
            cnt_q <= cnt_q + 1'b1;
          end
        end
        WR_BURST: begin
          if (mem_resp_i) cnt_q <= cnt_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign line_rdata_o = rdata_q;
  assign line_resp_o  = (state_q == DONE);
  assign mem_read_o   = (state_q == RD_BURST);
  assign mem_write_o  = (state_q == WR_BURST);
  assign mem_addr_o   = {addr_q, {s_offset{1'b0}}};
  assign mem_wdata_o  = (state_q == WR_BURST) ? wdata_q[int'(cnt_q)*s_beat +: s_beat] : '0;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_cacheline_adapter.sv
// Directed bench for cacheline_adapter: fills, write-backs, stalls, priority, reset, stray beats.
module tb_cacheline_adapter;
  import cache_mem_pkg::*;

  logic           clk = 1'b0;
  logic           rst;
  logic           line_read_i, line_write_i;
  logic [31:0]    line_addr_i;
  logic [255:0]   line_wdata_i;
  logic [255:0]   line_rdata_o;
  logic           line_resp_o, mem_read_o, mem_write_o;
  logic [31:0]    mem_addr_o;
  logic [63:0]    mem_wdata_o, mem_rdata_i;
  logic           mem_resp_i;
  adapter_state_t dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  logic [255:0] exp_q[$];

  localparam logic [255:0] R1 = {64'h4444444444444444, 64'h3333333333333333,
                                 64'h2222222222222222, 64'h1111111111111111};
  localparam logic [255:0] W1 = {64'hD, 64'hC, 64'hB, 64'hA};
  localparam logic [255:0] R2 = {64'h0123456789ABCDEF, 64'hFEDCBA9876543210,
                                 64'h5A5A5A5A5A5A5A5A, 64'hA5A5A5A5A5A5A5A5};
  localparam logic [255:0] R3 = {64'hCAFEF00DCAFEF00D, 64'h0000000000000001,
                                 64'h8000000000000000, 64'hFFFFFFFF00000000};

  // Observations recorded by the memory driver during one burst
  int           obs_resp_cyc, obs_resp_cnt, obs_beats, obs_addr_changes, obs_rw_drops;
  logic [31:0]  obs_addr;
  logic [255:0] obs_wline;
  logic         obs_saw_rd, obs_saw_wr;

  cacheline_adapter dut (
    .clk          (clk),
    .rst          (rst),
    .line_read_i  (line_read_i),
    .line_write_i (line_write_i),
    .line_addr_i  (line_addr_i),
    .line_wdata_i (line_wdata_i),
    .line_rdata_o (line_rdata_o),
    .line_resp_o  (line_resp_o),
    .mem_read_o   (mem_read_o),
    .mem_write_o  (mem_write_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_rdata_i  (mem_rdata_i),
    .mem_resp_i   (mem_resp_i),
    .dbg_state    (dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Memory model. Called at a negedge with the request already driven; cycle 1 is the
  // request cycle. First beat is returned immediately, then 'gap' idle cycles between beats.
  task automatic run_burst(input int gap, input logic [255:0] rline,
                           input bit drop_rd, input bit drop_wr);
    int stall;
    int idx;
    bit prev;
    obs_resp_cyc = 0; obs_resp_cnt = 0; obs_beats = 0;
    obs_addr_changes = 0; obs_rw_drops = 0;
    obs_addr = '0; obs_wline = '0; obs_saw_rd = 1'b0; obs_saw_wr = 1'b0;
    stall = gap; idx = 0; prev = 1'b0;
    for (int c = 1; c <= 80 && obs_resp_cyc == 0; c++) begin
      mem_resp_i  = 1'b0;
      mem_rdata_i = '0;
      if (mem_read_o || mem_write_o) begin
        if (!prev) obs_addr = mem_addr_o;
        else if (mem_addr_o !== obs_addr) obs_addr_changes++;
        obs_saw_rd |= mem_read_o;
        obs_saw_wr |= mem_write_o;
        if (stall >= gap) begin
          mem_resp_i = 1'b1;
          stall = 0;
          if (idx < 4) begin
            mem_rdata_i = rline[idx*64 +: 64];
            if (mem_write_o) obs_wline[idx*64 +: 64] = mem_wdata_o;
          end
          idx++;
          obs_beats++;
        end else begin
          stall++;
        end
        prev = 1'b1;
      end else if (prev && !line_resp_o) begin
        obs_rw_drops++;
      end
      if (line_resp_o) begin
        obs_resp_cyc = c;
        obs_resp_cnt++;
        if (drop_rd) line_read_i = 1'b0;
        if (drop_wr) line_write_i = 1'b0;
      end
      @(negedge clk);
    end
    mem_resp_i  = 1'b0;
    mem_rdata_i = '0;
    if (line_resp_o) obs_resp_cnt++;
  endtask

  task automatic start_read(input logic [31:0] addr);
    line_addr_i = addr;
    line_read_i = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    line_read_i = 1'b0; line_write_i = 1'b0; line_addr_i = '0; line_wdata_i = '0;
    mem_rdata_i = '0; mem_resp_i = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (dbg_state !== IDLE) begin n_fail++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, IDLE); end
    n_checks++; if (line_rdata_o !== '0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 0", line_rdata_o); end
    n_checks++; if ({line_resp_o, mem_read_o, mem_write_o} !== 3'b000) begin n_fail++; $display("FAIL reset_ctrl: got %b expected 000", {line_resp_o, mem_read_o, mem_write_o}); end
    n_checks++; if (mem_addr_o !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h expected 0", mem_addr_o); end
    n_checks++; if (mem_wdata_o !== 64'h0) begin n_fail++; $display("FAIL reset_wdata: got %h expected 0", mem_wdata_o); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_read_fill();
    exp_q.push_back(R1);
    start_read(32'h6000_0044);
    run_burst(0, R1, 1'b1, 1'b0);
    n_checks++; if (obs_addr !== 32'h6000_0040) begin n_fail++; $display("FAIL read_addr: got %h expected 60000040", obs_addr); end
    n_checks++; if (line_rdata_o !== exp_q[0]) begin n_fail++; $display("FAIL read_line: got %h expected %h", line_rdata_o, exp_q[0]); end
    n_checks++; if (obs_resp_cyc !== 6) begin n_fail++; $display("FAIL read_latency: got %0d expected 6", obs_resp_cyc); end
    n_checks++; if (obs_resp_cnt !== 1) begin n_fail++; $display("FAIL read_resp_pulses: got %0d expected 1", obs_resp_cnt); end
    n_checks++; if (obs_saw_wr !== 1'b0 || obs_beats !== 4) begin n_fail++; $display("FAIL read_beats: got wr=%b beats=%0d expected wr=0 beats=4", obs_saw_wr, obs_beats); end
  endtask

  task automatic test_write_back();
    logic [63:0] exp_beats [4];
    exp_beats = '{64'hA, 64'hB, 64'hC, 64'hD};
    line_addr_i  = 32'h0000_1FE0;
    line_wdata_i = W1;
    line_write_i = 1'b1;
    run_burst(0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (obs_wline[i*64 +: 64] !== exp_beats[i]) begin n_fail++; $display("FAIL write_beat%0d: got %h expected %h", i, obs_wline[i*64 +: 64], exp_beats[i]); end
    end
    n_checks++; if (obs_beats !== 4 || obs_saw_rd !== 1'b0 || obs_saw_wr !== 1'b1) begin n_fail++; $display("FAIL write_beats: got beats=%0d rd=%b wr=%b expected 4 0 1", obs_beats, obs_saw_rd, obs_saw_wr); end
    n_checks++; if (obs_addr !== 32'h0000_1FE0) begin n_fail++; $display("FAIL write_addr: got %h expected 00001fe0", obs_addr); end
    n_checks++; if (obs_resp_cyc !== 6 || obs_resp_cnt !== 1) begin n_fail++; $display("FAIL write_resp: got cyc=%0d pulses=%0d expected 6 1", obs_resp_cyc, obs_resp_cnt); end
    n_checks++; if (line_rdata_o !== exp_q[0]) begin n_fail++; $display("FAIL write_keeps_rdata: got %h expected %h", line_rdata_o, exp_q[0]); end
  endtask

  task automatic test_stalled_read();
    void'(exp_q.pop_front());
    exp_q.push_back(R2);
    start_read(32'h6000_011F);
    run_burst(2, R2, 1'b1, 1'b0);
    n_checks++; if (line_rdata_o !== exp_q[0]) begin n_fail++; $display("FAIL stall_line: got %h expected %h", line_rdata_o, exp_q[0]); end
    n_checks++; if (obs_resp_cyc !== 12) begin n_fail++; $display("FAIL stall_latency: got %0d expected 12", obs_resp_cyc); end
    n_checks++; if (obs_addr_changes !== 0 || obs_rw_drops !== 0) begin n_fail++; $display("FAIL stall_stable: got addr_changes=%0d drops=%0d expected 0 0", obs_addr_changes, obs_rw_drops); end
    n_checks++; if (obs_addr !== 32'h6000_0100) begin n_fail++; $display("FAIL stall_addr: got %h expected 60000100", obs_addr); end
  endtask

  task automatic test_simultaneous();
    line_addr_i  = 32'h0000_2020;
    line_wdata_i = W1;
    line_read_i  = 1'b1;
    line_write_i = 1'b1;
    run_burst(0, R3, 1'b0, 1'b1);
    n_checks++; if (obs_saw_wr !== 1'b1 || obs_saw_rd !== 1'b0) begin n_fail++; $display("FAIL simul_first_write: got rd=%b wr=%b expected rd=0 wr=1", obs_saw_rd, obs_saw_wr); end
    n_checks++; if (obs_wline !== W1 || obs_resp_cyc !== 6) begin n_fail++; $display("FAIL simul_write_data: got %h cyc=%0d expected %h cyc=6", obs_wline, obs_resp_cyc, W1); end
    n_checks++; if (line_rdata_o !== exp_q[0]) begin n_fail++; $display("FAIL simul_rdata_kept: got %h expected %h", line_rdata_o, exp_q[0]); end
    void'(exp_q.pop_front());
    exp_q.push_back(R3);
    run_burst(0, R3, 1'b1, 1'b0);
    n_checks++; if (obs_saw_rd !== 1'b1 || obs_saw_wr !== 1'b0 || obs_resp_cyc !== 6) begin n_fail++; $display("FAIL simul_then_read: got rd=%b wr=%b cyc=%0d expected 1 0 6", obs_saw_rd, obs_saw_wr, obs_resp_cyc); end
    n_checks++; if (line_rdata_o !== exp_q[0] || obs_addr !== 32'h0000_2020) begin n_fail++; $display("FAIL simul_read_line: got %h addr %h expected %h addr 00002020", line_rdata_o, obs_addr, exp_q[0]); end
  endtask

  task automatic test_reset_mid_burst();
    start_read(32'h6000_0080);
    @(negedge clk);                       // accepted; burst active
    mem_resp_i = 1'b1; mem_rdata_i = 64'h1111111111111111;
    @(negedge clk);
    mem_rdata_i = 64'h2222222222222222;
    @(negedge clk);
    mem_resp_i = 1'b0; mem_rdata_i = '0;
    line_read_i = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if (dbg_state !== IDLE) begin n_fail++; $display("FAIL midrst_state: got %0d expected %0d", dbg_state, IDLE); end
    n_checks++; if (line_rdata_o !== '0 || mem_addr_o !== 32'h0 || mem_wdata_o !== 64'h0) begin n_fail++; $display("FAIL midrst_data: got rdata=%h addr=%h wdata=%h expected zeros", line_rdata_o, mem_addr_o, mem_wdata_o); end
    n_checks++; if ({line_resp_o, mem_read_o, mem_write_o} !== 3'b000) begin n_fail++; $display("FAIL midrst_ctrl: got %b expected 000", {line_resp_o, mem_read_o, mem_write_o}); end
    rst = 1'b0;
    @(negedge clk);
    void'(exp_q.pop_front());
    exp_q.push_back(R2);
    start_read(32'h0000_3000);
    run_burst(0, R2, 1'b1, 1'b0);
    n_checks++; if (line_rdata_o !== exp_q[0] || obs_resp_cyc !== 6) begin n_fail++; $display("FAIL midrst_fresh_read: got %h cyc=%0d expected %h cyc=6", line_rdata_o, obs_resp_cyc, exp_q[0]); end
  endtask

  task automatic test_stray_response();
    mem_resp_i  = 1'b1;
    mem_rdata_i = 64'hDEADBEEFDEADBEEF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (dbg_state !== IDLE || line_resp_o !== 1'b0 || mem_read_o !== 1'b0 || line_rdata_o !== exp_q[0]) begin
        n_fail++;
        $display("FAIL stray_idle%0d: got state=%0d resp=%b rd=%b rdata=%h expected IDLE 0 0 %h", i, dbg_state, line_resp_o, mem_read_o, line_rdata_o, exp_q[0]);
      end
    end
    mem_resp_i = 1'b0;
    mem_rdata_i = '0;
    @(negedge clk);
    void'(exp_q.pop_front());
    exp_q.push_back(R1);
    start_read(32'h6000_0044);
    run_burst(0, R1, 1'b1, 1'b0);
    n_checks++; if (line_rdata_o !== exp_q[0] || obs_resp_cyc !== 6) begin n_fail++; $display("FAIL stray_followup_read: got %h cyc=%0d expected %h cyc=6", line_rdata_o, obs_resp_cyc, exp_q[0]); end
  endtask

  initial begin
    test_reset();
    test_read_fill();
    test_write_back();
    test_stalled_read();
    test_simultaneous();
    test_reset_mid_burst();
    test_stray_response();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
